// File: rtl/bus_rr_fabric_pkg.sv
// Shared definitions for the round-robin bus fabric: transfer direction,
// default bus widths and the slave window map.
package bus_rr_fabric_pkg;

  typedef enum logic {
    BUS_READ  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_dir_e;

  localparam int DEF_ADDR_WIDTH = 30;
  localparam int DEF_DATA_WIDTH = 32;

  localparam int MEM_SLV   = 0;
  localparam int MAX_SLV   = 8;
  localparam int SLV_IDX_W = 3;

  // Slave indices are compared at a fixed width so that selector values
  // beyond the populated windows still decode (as unmapped).
  function automatic logic [SLV_IDX_W-1:0] slv_idx(input int k);
    return SLV_IDX_W'(k);
  endfunction

endpackage

// File: rtl/bus_rr_fabric_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant, owner holds the bus
// while its request stays high, pointer follows the most recent owner.
module bus_rr_arbiter #(
  parameter int N_MST = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [N_MST-1:0] i_req,
  output logic [N_MST-1:0] o_grnt,
  output logic             o_grnt_chg
);

  localparam int IDX_W = $clog2(N_MST);

  logic [N_MST-1:0] r_grnt;
  logic [N_MST-1:0] w_grnt_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic             w_owned;
  int               w_dist;
  int               w_best;

  // Cyclic distance from the pointer: the master right after it is 1,
  // the pointer itself is N_MST, so the last owner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_best  = N_MST + 1;
    w_dist  = 0;
    for (int i = 0; i < N_MST; i++) begin
      w_dist = i - int'(r_ptr);
      if (w_dist <= 0) w_dist = w_dist + N_MST;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_found = 1'b1;
        w_pick  = IDX_W'(i);
      end
    end
  end

  assign w_owned = |(r_grnt & i_req);

  always_comb begin
    w_grnt_nxt = r_grnt;
    w_ptr_nxt  = r_ptr;
    if (!w_owned) begin
      w_grnt_nxt = '0;
      if (w_found) begin
        w_grnt_nxt[w_pick] = 1'b1;
        w_ptr_nxt          = w_pick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_grnt <= '0;
      r_ptr  <= IDX_W'(N_MST - 1);
    end else begin
      r_grnt <= w_grnt_nxt;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign o_grnt     = r_grnt;
  assign o_grnt_chg = (w_grnt_nxt != r_grnt);

endmodule

// File: rtl/bus_rr_fabric.sv
// Shared-bus fabric: round-robin arbitration, owner mux, slave decode,
// read-data return, unmapped-window errors and wait-state timeout.
module bus_rr_fabric
  import bus_rr_fabric_pkg::*;
#(
  parameter int N_MST      = 4,
  parameter int N_SLV      = 8,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic [N_MST-1:0]            m_req,
  input  logic [N_MST-1:0]            m_as,
  input  logic [N_MST*ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MST-1:0]            m_wr,
  input  logic [N_MST*DATA_WIDTH-1:0] m_wr_data,
  output logic [N_MST-1:0]            m_grnt,
  output logic                        m_rdy,
  output logic [DATA_WIDTH-1:0]       m_rd_data,
  output logic                        m_err,
  output logic                        s_as,
  output logic [ADDR_WIDTH-1:0]       s_addr,
  output logic                        s_wr,
  output logic [DATA_WIDTH-1:0]       s_wr_data,
  output logic [N_SLV-1:0]            s_cs,
  input  logic [N_SLV-1:0]            s_rdy,
  input  logic [N_SLV*DATA_WIDTH-1:0] s_rd_data
);

  localparam int SEL_W = $clog2(N_SLV);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit TO_EN = (TIMEOUT > 0);

  logic [N_MST-1:0]      w_grnt;
  logic                  w_grnt_chg;
  logic [SEL_W-1:0]      w_sel;
  logic [SLV_IDX_W-1:0]  w_sel_ext;
  logic [N_SLV-1:0]      w_hit;
  logic                  w_mapped;
  logic                  w_slv_rdy;
  logic [DATA_WIDTH-1:0] w_slv_data;
  logic                  w_done;
  logic                  w_unmapped;
  logic                  w_timeout;
  logic [CNT_W-1:0]      r_wait_cnt;

  bus_rr_arbiter #(
    .N_MST (N_MST)
  ) u_arbiter (
    .clk        (clk),
    .rst_       (rst_),
    .i_req      (m_req),
    .o_grnt     (w_grnt),
    .o_grnt_chg (w_grnt_chg)
  );

  assign m_grnt = w_grnt;

  // Grant is one-hot, so at most one master's fields reach the slave side.
  always_comb begin
    s_as      = 1'b0;
    s_addr    = '0;
    s_wr      = 1'b0;
    s_wr_data = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (w_grnt[i]) begin
        s_as      = m_as[i];
        s_addr    = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wr      = m_wr[i];
        s_wr_data = m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_sel     = s_addr[ADDR_WIDTH-1 -: SEL_W];
  assign w_sel_ext = SLV_IDX_W'(w_sel);

  always_comb begin
    w_hit      = '0;
    w_slv_rdy  = 1'b0;
    w_slv_data = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (w_sel_ext == slv_idx(k)) begin
        w_hit[k]   = 1'b1;
        w_slv_rdy  = s_rdy[k];
        w_slv_data = s_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_mapped   = |w_hit;
  assign s_cs       = s_as ? w_hit : '0;
  assign w_done     = s_as & w_mapped & w_slv_rdy;
  assign w_unmapped = s_as & ~w_mapped;
  // A ready slave always beats the timeout in the same cycle.
  assign w_timeout  = TO_EN & s_as & w_mapped & ~w_slv_rdy & (r_wait_cnt == CNT_W'(TO_M1));

  assign m_rdy     = w_done | w_unmapped | w_timeout;
  assign m_err     = w_unmapped | w_timeout;
  assign m_rd_data = w_done ? w_slv_data : '0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wait_cnt <= '0;
    end else if (m_rdy || !s_as || w_grnt_chg) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != '1) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_rr_fabric.sv
// Directed bench for bus_rr_fabric: arbitration order, read/write paths,
// timeout, unmapped windows (N_SLV=6 instance) and reset mid-transfer.
module tb_bus_rr_fabric;
  import bus_rr_fabric_pkg::*;

  localparam int NM  = 4;
  localparam int NS  = 8;
  localparam int NS6 = 6;
  localparam int AW  = 30;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst_;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_as;
  logic [NM*AW-1:0] m_addr;
  logic [NM-1:0]    m_wr;
  logic [NM*DW-1:0] m_wr_data;

  logic [NM-1:0] m_grnt;
  logic          m_rdy;
  logic [DW-1:0] m_rd_data;
  logic          m_err;
  logic          s_as;
  logic [AW-1:0] s_addr;
  logic          s_wr;
  logic [DW-1:0] s_wr_data;
  logic [NS-1:0] s_cs;
  logic [NS-1:0] s_rdy;
  logic [NS*DW-1:0] s_rd_data;

  logic [NM-1:0]     grnt6;
  logic              rdy6;
  logic [DW-1:0]     rdData6;
  logic              err6;
  logic              as6;
  logic [AW-1:0]     addr6;
  logic              wr6;
  logic [DW-1:0]     wrData6;
  logic [NS6-1:0]    cs6;
  logic [NS6-1:0]    slvRdy6;
  logic [NS6*DW-1:0] slvRdData6;

  logic [DW-1:0] memArray [0:255];
  logic [DW-1:0] slvData  [0:NS-1];
  logic [DW-1:0] slvData6 [0:NS6-1];

  logic [NM-1:0] reqSeq  [0:3];
  logic [NM-1:0] grntSeq [0:3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_rr_fabric #(
    .N_MST(NM), .N_SLV(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)
  ) u_dut (
    .clk(clk), .rst_(rst_), .m_req(m_req), .m_as(m_as), .m_addr(m_addr),
    .m_wr(m_wr), .m_wr_data(m_wr_data), .m_grnt(m_grnt), .m_rdy(m_rdy),
    .m_rd_data(m_rd_data), .m_err(m_err), .s_as(s_as), .s_addr(s_addr),
    .s_wr(s_wr), .s_wr_data(s_wr_data), .s_cs(s_cs), .s_rdy(s_rdy),
    .s_rd_data(s_rd_data)
  );

  bus_rr_fabric #(
    .N_MST(NM), .N_SLV(NS6), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)
  ) u_dut6 (
    .clk(clk), .rst_(rst_), .m_req(m_req), .m_as(m_as), .m_addr(m_addr),
    .m_wr(m_wr), .m_wr_data(m_wr_data), .m_grnt(grnt6), .m_rdy(rdy6),
    .m_rd_data(rdData6), .m_err(err6), .s_as(as6), .s_addr(addr6),
    .s_wr(wr6), .s_wr_data(wrData6), .s_cs(cs6), .s_rdy(slvRdy6),
    .s_rd_data(slvRdData6)
  );

  // Slave 0 behaves as a small memory; the rest return fixed words.
  always_comb begin
    s_rd_data = '0;
    for (int k = 0; k < NS; k++) begin
      if (k == MEM_SLV) s_rd_data[k*DW +: DW] = memArray[s_addr[7:0]];
      else              s_rd_data[k*DW +: DW] = slvData[k];
    end
  end

  always_comb begin
    slvRdData6 = '0;
    for (int k = 0; k < NS6; k++) slvRdData6[k*DW +: DW] = slvData6[k];
  end

  // Memory write sampled mid-cycle, clear of the DUT's clock edge.
  always @(negedge clk) begin
    if (s_as && s_cs[MEM_SLV] && (s_wr == BUS_WRITE) && s_rdy[MEM_SLV])
      memArray[s_addr[7:0]] <= s_wr_data;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic setMaster(input int idx, input logic as, input logic [AW-1:0] addr,
                           input logic wr, input logic [DW-1:0] data);
    m_as[idx]              = as;
    m_addr[idx*AW +: AW]   = addr;
    m_wr[idx]              = wr;
    m_wr_data[idx*DW +: DW] = data;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    m_req = '1;
    #12;
    checks++; if (m_grnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grnt got=%b want=0000", m_grnt); end
    checks++; if (s_as !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_as got=%b want=0", s_as); end
    checks++; if (s_cs !== 8'h00) begin errors++; $display("[TB] FAIL reset_s_cs got=%b want=00000000", s_cs); end
    checks++; if (m_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_rdy got=%b want=0", m_rdy); end
    rst_ = 1'b1;
    step();
    checks++; if (m_grnt !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_grant got=%b want=0001", m_grnt); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      m_req = reqSeq[i];
      step();
      checks++;
      if (m_grnt !== grntSeq[i]) begin
        errors++; $display("[TB] FAIL rr_handover_%0d got=%b want=%b", i, m_grnt, grntSeq[i]);
      end
    end
    m_req = '0;
    step();
    checks++; if (m_grnt !== 4'b0000) begin errors++; $display("[TB] FAIL rr_no_parking got=%b want=0000", m_grnt); end
  endtask

  task automatic test_read_slave1();
    slvData[1] = 32'h0000_0001;
    s_rdy      = 8'b0000_0010;
    m_req      = 4'b0010;
    setMaster(1, 1'b1, 30'h0800_0000, BUS_READ, '0);
    step();
    #1;
    checks++; if (m_grnt !== 4'b0010) begin errors++; $display("[TB] FAIL rd1_grant got=%b want=0010", m_grnt); end
    checks++; if (s_addr !== 30'h0800_0000) begin errors++; $display("[TB] FAIL rd1_s_addr got=%h want=08000000", s_addr); end
    checks++; if (s_cs !== 8'b0000_0010) begin errors++; $display("[TB] FAIL rd1_s_cs got=%b want=00000010", s_cs); end
    checks++; if (m_rd_data !== 32'h1) begin errors++; $display("[TB] FAIL rd1_data got=%h want=00000001", m_rd_data); end
    checks++; if ({m_rdy, m_err} !== 2'b10) begin errors++; $display("[TB] FAIL rd1_rdy_err got=%b%b want=10", m_rdy, m_err); end
    m_req = '0;
    setMaster(1, 1'b0, '0, BUS_READ, '0);
    step();
  endtask

  task automatic test_write_read_mem();
    s_rdy = 8'b0000_0001;
    m_req = 4'b1000;
    setMaster(3, 1'b1, 30'h010, BUS_WRITE, 32'hDEAD_BEEF);
    step();
    #1;
    checks++; if (m_grnt !== 4'b1000) begin errors++; $display("[TB] FAIL wr_grant got=%b want=1000", m_grnt); end
    checks++; if (s_cs !== 8'b0000_0001) begin errors++; $display("[TB] FAIL wr_s_cs got=%b want=00000001", s_cs); end
    checks++; if ({s_wr, s_wr_data} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL wr_fields got=%b/%h want=1/deadbeef", s_wr, s_wr_data); end
    checks++; if ({m_rdy, m_err} !== 2'b10) begin errors++; $display("[TB] FAIL wr_rdy_err got=%b%b want=10", m_rdy, m_err); end
    step();
    m_wr[3] = BUS_READ;
    #1;
    checks++; if (m_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL mem_readback got=%h want=deadbeef", m_rd_data); end
    m_addr[3*AW +: AW] = 30'h011;
    #1;
    checks++; if (m_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL mem_other_addr got=%h want=00000000", m_rd_data); end
    m_req = '0;
    setMaster(3, 1'b0, '0, BUS_READ, '0);
    step();
  endtask

  task automatic test_timeout();
    logic earlyRdy;
    slvData[3] = 32'h1234_5678;
    s_rdy      = 8'b0000_0000;
    for (int pass = 0; pass < 2; pass++) begin
      earlyRdy = 1'b0;
      m_req    = 4'b0100;
      setMaster(2, 1'b1, 30'h1800_0000, BUS_READ, '0);
      step();
      for (int c = 1; c < 16; c++) begin
        #1;
        if (m_rdy !== 1'b0) earlyRdy = 1'b1;
        step();
      end
      if (pass == 1) s_rdy[3] = 1'b1;
      #1;
      checks++; if (earlyRdy !== 1'b0) begin errors++; $display("[TB] FAIL to_early_%0d got=1 want=0", pass); end
      if (pass == 0) begin
        checks++; if (s_cs !== 8'b0000_1000) begin errors++; $display("[TB] FAIL to_s_cs got=%b want=00001000", s_cs); end
        checks++; if ({m_rdy, m_err} !== 2'b11) begin errors++; $display("[TB] FAIL to_rdy_err got=%b%b want=11", m_rdy, m_err); end
        checks++; if (m_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL to_data got=%h want=00000000", m_rd_data); end
      end else begin
        checks++; if ({m_rdy, m_err} !== 2'b10) begin errors++; $display("[TB] FAIL to_race_rdy_err got=%b%b want=10", m_rdy, m_err); end
        checks++; if (m_rd_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL to_race_data got=%h want=12345678", m_rd_data); end
      end
      m_req = '0;
      setMaster(2, 1'b0, '0, BUS_READ, '0);
      s_rdy = '0;
      step();
    end
  endtask

  task automatic test_unmapped();
    slvRdy6 = '0;
    for (int k = 0; k < NS6; k++) slvData6[k] = 32'hFFFF_FFFF;
    m_req = 4'b0001;
    setMaster(0, 1'b1, 30'h3800_0000, BUS_READ, '0);
    step();
    #1;
    checks++; if (grnt6 !== 4'b0001) begin errors++; $display("[TB] FAIL um_grant got=%b want=0001", grnt6); end
    checks++; if (cs6 !== 6'b000000) begin errors++; $display("[TB] FAIL um_s_cs got=%b want=000000", cs6); end
    checks++; if ({rdy6, err6} !== 2'b11) begin errors++; $display("[TB] FAIL um_rdy_err got=%b%b want=11", rdy6, err6); end
    checks++; if (rdData6 !== 32'h0) begin errors++; $display("[TB] FAIL um_data got=%h want=00000000", rdData6); end
    checks++; if ({s_cs, m_rdy} !== {8'b1000_0000, 1'b0}) begin errors++; $display("[TB] FAIL n8_sel7 got=%b/%b want=10000000/0", s_cs, m_rdy); end
    slvData6[5] = 32'hCAFE_0005;
    slvRdy6[5]  = 1'b1;
    m_addr[0 +: AW] = 30'h2800_0000;
    #1;
    checks++; if (cs6 !== 6'b100000) begin errors++; $display("[TB] FAIL n6_top_cs got=%b want=100000", cs6); end
    checks++; if ({rdy6, err6, rdData6} !== {2'b10, 32'hCAFE_0005}) begin errors++; $display("[TB] FAIL n6_top_read got=%b%b/%h want=10/cafe0005", rdy6, err6, rdData6); end
    m_req = '0;
    setMaster(0, 1'b0, '0, BUS_READ, '0);
    slvRdy6 = '0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    logic seen;
    s_rdy = '0;
    m_req = 4'b0100;
    setMaster(2, 1'b1, 30'h1800_0000, BUS_READ, '0);
    step();
    repeat (5) step();
    #1;
    rst_ = 1'b0;
    #1;
    checks++; if ({m_grnt, s_as, s_cs} !== 13'h0) begin errors++; $display("[TB] FAIL rstmid_grant_cs got=%b/%b/%b want=0000/0/00000000", m_grnt, s_as, s_cs); end
    checks++; if ({m_rdy, m_err, m_rd_data, s_addr} !== '0) begin errors++; $display("[TB] FAIL rstmid_outputs got=%b%b/%h/%h want=00/0/0", m_rdy, m_err, m_rd_data, s_addr); end
    step();
    checks++; if (m_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_rdy got=%b want=0", m_rdy); end
    rst_ = 1'b1;
    step();
    n    = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      #1;
      if (m_rdy === 1'b1) begin
        seen = 1'b1;
        n    = c;
      end else begin
        step();
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL rstmid_timeout_wait got=no m_rdy in 40 cycles want=cycle 16");
    end else if (n != 16 || m_err !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_timeout_cycle got=%0d err=%b want=16 err=1", n, m_err);
    end
    m_req = '0;
    setMaster(2, 1'b0, '0, BUS_READ, '0);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=simulation still running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) memArray[a] = '0;
    for (int k = 0; k < NS; k++) slvData[k] = '0;
    for (int k = 0; k < NS6; k++) slvData6[k] = '0;
    reqSeq[0]  = 4'b1110; grntSeq[0] = 4'b0010;
    reqSeq[1]  = 4'b1101; grntSeq[1] = 4'b0100;
    reqSeq[2]  = 4'b1011; grntSeq[2] = 4'b1000;
    reqSeq[3]  = 4'b0111; grntSeq[3] = 4'b0001;
    rst_      = 1'b0;
    m_req     = '0;
    m_as      = '0;
    m_addr    = '0;
    m_wr      = '0;
    m_wr_data = '0;
    s_rdy     = '0;
    slvRdy6   = '0;

    test_reset();
    test_round_robin();
    test_read_slave1();
    test_write_read_mem();
    test_timeout();
    test_unmapped();
    test_reset_mid_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
